axi_stream_pl2ps: RTL and testbench
===================================

Name: axi_stream_pl2ps

Overview:
- PL-to-PS return path. Accepts free-running 32-bit samples from PL audio/analysis logic, frames them into fixed-length AXI4-Stream packets and presents them to the PS DMA S2MM port.
- FIFO absorbs DMA backpressure. Samples arriving while the FIFO is full are dropped and flagged.
- TLAST marks the last beat of every FRAME_LEN-sample frame.

Parameters:
- FRAME_LEN, 256, beats per packet; range 2..65535.
- FIFO_DEPTH, 16, FIFO entries; power of 2, ≥2.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- ENABLE  in  1  level; start/continue framing.
- SAMPLE_DATA  in  32  PL sample.
- SAMPLE_VALID  in  1  one-cycle strobe; no ready, source cannot stall.
- OVF_CLR  in  1  clears OVERFLOW; single-cycle pulse.
- M_AXIS_TVALID  out  1  AXIS valid.
- M_AXIS_TDATA  out  32  AXIS data.
- M_AXIS_TLAST  out  1  end of frame.
- M_AXIS_TREADY  in  1  AXIS ready from DMA.
- BUSY  out  1  state ≠ IDLE.
- OVERFLOW  out  1  sticky drop flag.

Behaviour:
- Reset (ARESETN low, asynchronous):
  - state=IDLE; FIFO pointers and count=0.
  - frame counter=0; OVERFLOW=0; BUSY=0; M_AXIS_TVALID=0.
  - TDATA/TLAST don't-care while TVALID=0; drive 0.
  - Reset mid-packet flushes the FIFO. The partial packet is abandoned; the DMA side is reset by software.
- FSM:
  - IDLE: no writes. ENABLE=1 → RUN, with frame counter forced to 0.
  - RUN: each write takes SAMPLE_VALID=1 and (not full, or read in same cycle). ENABLE=0 → DRAIN.
  - DRAIN: keeps accepting samples until the frame completes. The write carrying the last beat → IDLE. If frame counter=0 on entry to DRAIN (frame boundary), go directly to IDLE with no further writes. ENABLE re-asserting in DRAIN → RUN, no frame restart.
- Framing is on the write side:
  - Each FIFO entry is 33 bits {last, data}; last=1 when frame counter = FRAME_LEN-1.
  - Frame counter increments per accepted write and wraps to 0 after FRAME_LEN-1.
  - Dropped samples do not advance the counter, so every packet is exactly FRAME_LEN beats.
- Overflow:
  - SAMPLE_VALID=1 in RUN/DRAIN with FIFO full and no same-cycle read → sample dropped; OVERFLOW=1 next cycle.
  - Full with same-cycle handshake → write accepted, count unchanged.
  - SAMPLE_VALID in IDLE is ignored and is not an overflow.
  - OVF_CLR and a new drop in the same cycle → OVERFLOW stays 1 (set wins).
- Read side (first-word fall-through):
  - M_AXIS_TVALID = count≠0; TDATA/TLAST = head entry.
  - Handshake TVALID&TREADY pops one entry.
  - Latency: sample written at edge t is visible on TDATA with TVALID=1 after edge t.
  - TVALID/TDATA/TLAST hold stable while TVALID=1 and TREADY=0 (AXIS rule).
  - Empty and write in same cycle → TVALID rises next cycle; no bypass.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.
- BUSY drops when the FSM reaches IDLE. The FIFO may still hold data, which continues to drain to the DMA.

Optional Feature:
- Macro: AXI_STREAM_PL2PS_OVF_CNT_EN.
- Defined: adds output OVF_COUNT [15:0]. It counts dropped samples, saturates at 16'hFFFF, resets to 0 on ARESETN, and clears on OVF_CLR. A clear and a drop in the same cycle → value 1.
- Undefined: port absent; only the sticky OVERFLOW flag exists. All other behaviour is identical.

Test Plan (FRAME_LEN=4, FIFO_DEPTH=4):
- ENABLE=1, TREADY=1, samples 0x10..0x17 on consecutive cycles → 8 beats, same order, each 1 cycle after write; TLAST=1 on 0x13 and 0x17 only; OVERFLOW=0.
- TREADY=0, 6 samples 0xA0..0xA5 → 0xA0..0xA3 stored, 0xA4/0xA5 dropped, OVERFLOW=1 (OVF_COUNT=2 if enabled); TDATA held at 0xA0; then TREADY=1 and 4 more samples → next frame is 0xA6..0xA9, TLAST on 0xA3 and 0xA9.
- FIFO full, TREADY=1 and SAMPLE_VALID=1 in same cycle → no drop, count stays 4, OVERFLOW stays 0.
- ENABLE deasserted after 2nd sample of a frame → 2 more samples accepted (2nd with TLAST), BUSY=0 after that write, later samples ignored with OVERFLOW=0.
- ARESETN pulsed low mid-frame with 3 entries queued → TVALID=0 immediately, BUSY=0. After re-enable, first sample is frame beat 0 (TLAST after 4 beats).
- OVF_CLR pulse coincident with a drop → OVERFLOW remains 1; isolated OVF_CLR → OVERFLOW=0 next cycle.

Source files
------------

// File: rtl/axi_stream_pl2ps.sv
// PL-to-PS sample framer: free-running 32-bit samples -> FIFO -> fixed-length AXI4-Stream packets.
// Optional macro AXI_STREAM_PL2PS_OVF_CNT_EN adds a saturating 16-bit dropped-sample counter (OVF_COUNT).
module axi_stream_pl2ps #(
  parameter int FRAME_LEN  = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        ENABLE,
  input  logic [31:0] SAMPLE_DATA,
  input  logic        SAMPLE_VALID,
  input  logic        OVF_CLR,
  output logic        M_AXIS_TVALID,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY,
  output logic        BUSY,
  output logic        OVERFLOW,
`ifdef AXI_STREAM_PL2PS_OVF_CNT_EN
  output logic [15:0] OVF_COUNT,
`endif
  output logic [1:0]  dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [32:0]      mem_q [FIFO_DEPTH];

  logic             wr_allowed;
  logic             wr_en;
  logic             rd_en;
  logic             drop;
  logic             wr_last;
  logic             full;
  logic [32:0]      head;

  // Handshake: a beat transfers on any edge where M_AXIS_TVALID and M_AXIS_TREADY are both high;
  // TVALID, TDATA and TLAST never change while TVALID is high and TREADY is low.
  assign full    = (count_q == FULL_CNT);
  assign rd_en   = (count_q != '0) && M_AXIS_TREADY;
  assign wr_last = (frame_cnt_q == LAST_BEAT);
  assign wr_en   = wr_allowed && SAMPLE_VALID && (!full || rd_en);
  assign drop    = wr_allowed && SAMPLE_VALID && full && !rd_en;
  assign head    = mem_q[rd_ptr_q];

  // FSM state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (ENABLE) state_d = ST_RUN;
      ST_RUN:   if (!ENABLE) state_d = ST_DRAIN;
      ST_DRAIN: begin
        // A drain entered on a frame boundary has nothing left to complete.
        if (ENABLE)                      state_d = ST_RUN;
        else if (frame_cnt_q == '0)      state_d = ST_IDLE;
        else if (wr_en && wr_last)       state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    wr_allowed = 1'b0;
    BUSY       = 1'b0;
    unique case (state_q)
      ST_IDLE:  begin wr_allowed = 1'b0;                 BUSY = 1'b0; end
      ST_RUN:   begin wr_allowed = 1'b1;                 BUSY = 1'b1; end
      ST_DRAIN: begin wr_allowed = (frame_cnt_q != '0);  BUSY = 1'b1; end
      default:  begin wr_allowed = 1'b0;                 BUSY = 1'b0; end
    endcase
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_q == ST_IDLE && ENABLE) frame_cnt_d = '0;
    else if (wr_en)                   frame_cnt_d = wr_last ? '0 : frame_cnt_q + 1'b1;
  end

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (OVF_CLR) overflow_d = 1'b0;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      frame_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only observed once count covers them.
  always_ff @(posedge ACLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= {wr_last, SAMPLE_DATA};
  end

`ifdef AXI_STREAM_PL2PS_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (OVF_CLR)                          ovf_cnt_d = drop ? 16'd1 : 16'd0;
    else if (drop && ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) ovf_cnt_q <= 16'd0;
    else          ovf_cnt_q <= ovf_cnt_d;
  end

  assign OVF_COUNT = ovf_cnt_q;
`endif

  assign M_AXIS_TVALID = (count_q != '0);
  assign M_AXIS_TDATA  = M_AXIS_TVALID ? head[31:0] : 32'd0;
  assign M_AXIS_TLAST  = M_AXIS_TVALID ? head[32]   : 1'b0;
  assign OVERFLOW      = overflow_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_axi_stream_pl2ps.sv
// Bench for axi_stream_pl2ps with FRAME_LEN=4, FIFO_DEPTH=4; expected beats flow through exp_q.
// Define AXI_STREAM_PL2PS_OVF_CNT_EN to also check OVF_COUNT.
module tb_axi_stream_pl2ps;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic        ovf_clr;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast;
  logic        tready;
  logic        busy;
  logic        overflow;
  logic [1:0]  dbg_state;
`ifdef AXI_STREAM_PL2PS_OVF_CNT_EN
  logic [15:0] ovf_count;
`endif

  logic [32:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  axi_stream_pl2ps #(.FRAME_LEN(4), .FIFO_DEPTH(4)) dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .ENABLE        (enable),
    .SAMPLE_DATA   (sample_data),
    .SAMPLE_VALID  (sample_valid),
    .OVF_CLR       (ovf_clr),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TLAST  (tlast),
    .M_AXIS_TREADY (tready),
    .BUSY          (busy),
    .OVERFLOW      (overflow),
`ifdef AXI_STREAM_PL2PS_OVF_CNT_EN
    .OVF_COUNT     (ovf_count),
`endif
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_ovf_count(input string tag, input logic [15:0] exp);
`ifdef AXI_STREAM_PL2PS_OVF_CNT_EN
    check(tag, ovf_count, exp);
`endif
  endtask

  // Called at posedge+1; presents one sample for exactly one edge.
  task automatic drive(input logic [31:0] data, input bit push, input bit last, input bit clr);
    sample_data  = data;
    sample_valid = 1'b1;
    ovf_clr      = clr;
    if (push) exp_q.push_back({last, data});
    @(posedge clk); #1;
    sample_valid = 1'b0;
    ovf_clr      = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check({tag, "_drain"}, exp_q.size(), 0);
    check({tag, "_tvalid_low"}, tvalid, 1'b0);
  endtask

  // scoreboard: handshake decided at negedge, takes effect on the next posedge
  initial begin
    logic [32:0] exp;
    forever begin
      @(negedge clk);
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {tlast, tdata}, 33'h0);
        end else begin
          exp = exp_q.pop_front();
          check("beat", {tlast, tdata}, exp);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; sample_data = '0; sample_valid = 1'b0;
    ovf_clr = 1'b0; tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_tdata", {tlast, tdata}, 33'h0);
    check_ovf_count("rst_ovf_count", 16'd0);
    rst_n = 1'b1;
    idle_cycle();

    // T1: streaming with TREADY high, two frames
    tready = 1'b1; enable = 1'b1;
    idle_cycle();
    check("t1_busy", busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive(32'h10 + i, 1'b1, (i % 4) == 3, 1'b0);
      check("t1_latency_tdata", tdata, 32'h10 + i);
      check("t1_latency_tlast", tlast, (i % 4) == 3);
    end
    wait_drain("t1");
    check("t1_overflow", overflow, 1'b0);

    // T2: backpressure, drops, then release
    tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(32'hA0 + i, i < 4, i == 3, 1'b0);
      if (i == 3) check("t2_no_ovf_yet", overflow, 1'b0);
    end
    check("t2_overflow", overflow, 1'b1);
    check("t2_hold_tvalid", tvalid, 1'b1);
    check("t2_hold_tdata", tdata, 32'hA0);
    check_ovf_count("t2_ovf_count", 16'd2);
    tready = 1'b1;
    for (int i = 6; i < 10; i++) drive(32'hA0 + i, 1'b1, i == 9, 1'b0);
    wait_drain("t2");
    ovf_clr = 1'b1;
    idle_cycle();
    ovf_clr = 1'b0;
    check("t2_ovf_cleared", overflow, 1'b0);
    check_ovf_count("t2_ovf_count_cleared", 16'd0);

    // T3: full FIFO with simultaneous read and write
    tready = 1'b0;
    for (int i = 0; i < 4; i++) drive(32'hB0 + i, 1'b1, i == 3, 1'b0);
    check("t3_full_head", tdata, 32'hB0);
    tready = 1'b1;
    drive(32'hB4, 1'b1, 1'b0, 1'b0);
    check("t3_no_drop", overflow, 1'b0);
    check("t3_head_after", tdata, 32'hB1);

    // T4: ENABLE drops after the 2nd sample of a frame
    drive(32'hB5, 1'b1, 1'b0, 1'b0);
    enable = 1'b0;
    idle_cycle();
    check("t4_drain_busy", busy, 1'b1);
    drive(32'hC0, 1'b1, 1'b0, 1'b0);
    check("t4_busy_mid", busy, 1'b1);
    drive(32'hC1, 1'b1, 1'b1, 1'b0);
    check("t4_busy_done", busy, 1'b0);
    drive(32'hC2, 1'b0, 1'b0, 1'b0);
    drive(32'hC3, 1'b0, 1'b0, 1'b0);
    check("t4_ignored_no_ovf", overflow, 1'b0);
    wait_drain("t4");

    // T5: reset mid-frame with entries queued
    tready = 1'b0; enable = 1'b1;
    idle_cycle();
    for (int i = 0; i < 3; i++) drive(32'hD0 + i, 1'b0, 1'b0, 1'b0);
    check("t5_queued", tvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_tvalid", tvalid, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tready = 1'b1;
    idle_cycle();
    for (int i = 0; i < 4; i++) begin
      drive(32'hE0 + i, 1'b1, i == 3, 1'b0);
      check("t5_tlast", tlast, i == 3);
    end
    wait_drain("t5");

    // T6: OVF_CLR against a drop, then isolated clear
    tready = 1'b0;
    for (int i = 0; i < 4; i++) drive(32'hF0 + i, 1'b1, i == 3, 1'b0);
    drive(32'hF4, 1'b0, 1'b0, 1'b0);
    check("t6_ovf_set", overflow, 1'b1);
    check_ovf_count("t6_ovf_count_1", 16'd1);
    drive(32'hF5, 1'b0, 1'b0, 1'b1);
    check("t6_set_wins", overflow, 1'b1);
    check_ovf_count("t6_clr_and_drop", 16'd1);
    ovf_clr = 1'b1;
    idle_cycle();
    ovf_clr = 1'b0;
    check("t6_isolated_clr", overflow, 1'b0);
    check_ovf_count("t6_count_clr", 16'd0);
    tready = 1'b1;
    wait_drain("t6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
